// File: rtl/enemy_pkg.sv
// Shared types and ROM word layout for the enemy path reader.
// The layout of the ROM word is {end, x, y}, with y in the LSBs.
package enemy_pkg;

    localparam int XWIDTH_DEF = 10;
    localparam int YWIDTH_DEF = 10;

    localparam int Y_LSB   = 0;
    localparam int Y_MSB   = YWIDTH_DEF - 1;
    localparam int X_LSB   = YWIDTH_DEF;
    localparam int X_MSB   = X_LSB + XWIDTH_DEF - 1;
    localparam int END_BIT = XWIDTH_DEF + YWIDTH_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT,
        S_DONE
    } path_state_t;

    typedef enum logic {
        CAUSE_ESCAPE = 1'b0,
        CAUSE_KILL   = 1'b1
    } exit_cause_t;

endpackage

// File: rtl/enemy_path_reader_step_timer.sv
// Counts tick strobes for one waypoint; done fires on the last tick of the step.
module step_timer #(
    parameter int STEP_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam logic [7:0] LAST_CNT = 8'(STEP_TICKS - 1);

    logic [7:0] cnt_reg;

    assign done = tick && (cnt_reg == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= done ? 8'd0 : cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/enemy_path_reader.sv
// Walks one enemy's waypoint list in the path ROM and reports its position,
// pulsing flip when the path ends or the enemy is destroyed.
module enemy_path_reader
    import enemy_pkg::*;
#(
    parameter int ADRESSWIDTH = 10,
    parameter int XWIDTH      = XWIDTH_DEF,
    parameter int YWIDTH      = YWIDTH_DEF,
    parameter int STEP_TICKS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spawn,
    input  logic [ADRESSWIDTH-1:0]   adr_start,
    input  logic                     tick,
    input  logic                     destroyed,
    output logic [ADRESSWIDTH-1:0]   rom_adr,
    input  logic [XWIDTH+YWIDTH:0]   rom_data,
    output logic [XWIDTH-1:0]        xpos,
    output logic [YWIDTH-1:0]        ypos,
    output logic                     enemy_active,
    output logic                     escaped,
    output logic                     flip
);

    path_state_t              state_reg, state_next;
    exit_cause_t              cause_reg, cause_next;
    logic [ADRESSWIDTH-1:0]   ptr_reg, ptr_next;
    logic [XWIDTH-1:0]        xpos_reg, xpos_next;
    logic [YWIDTH-1:0]        ypos_reg, ypos_next;
    logic                     active_reg, active_next;
    logic                     escaped_reg, escaped_next;
    logic                     flip_reg, flip_next;
    logic                     timer_clear;
    logic                     timer_done;

    // The timer only sees ticks while parked on a waypoint.
    step_timer #(
        .STEP_TICKS(STEP_TICKS)
    ) u_step_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick && (state_reg == S_WAIT)),
        .done  (timer_done)
    );

    assign rom_adr      = ptr_reg;
    assign xpos         = xpos_reg;
    assign ypos         = ypos_reg;
    assign enemy_active = active_reg;
    assign escaped      = escaped_reg;
    assign flip         = flip_reg;

    always_comb begin
        state_next   = state_reg;
        cause_next   = cause_reg;
        ptr_next     = ptr_reg;
        xpos_next    = xpos_reg;
        ypos_next    = ypos_reg;
        active_next  = active_reg;
        escaped_next = 1'b0;
        flip_next    = 1'b0;
        timer_clear  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (spawn) begin
                    ptr_next   = adr_start;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (destroyed) begin
                    cause_next = CAUSE_KILL;
                    state_next = S_DONE;
                end else begin
                    state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                // A kill takes precedence over an end word arriving this cycle.
                if (destroyed) begin
                    cause_next = CAUSE_KILL;
                    state_next = S_DONE;
                end else if (rom_data[END_BIT]) begin
                    cause_next = CAUSE_ESCAPE;
                    state_next = S_DONE;
                end else begin
                    xpos_next   = rom_data[X_MSB:X_LSB];
                    ypos_next   = rom_data[Y_MSB:Y_LSB];
                    active_next = 1'b1;
                    timer_clear = 1'b1;
                    ptr_next    = ptr_reg + ADRESSWIDTH'(1);
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (destroyed) begin
                    cause_next = CAUSE_KILL;
                    state_next = S_DONE;
                end else if (timer_done) begin
                    state_next = S_FETCH;
                end
            end
            S_DONE: begin
                flip_next    = 1'b1;
                active_next  = 1'b0;
                escaped_next = (cause_reg == CAUSE_ESCAPE);
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cause_reg   <= CAUSE_ESCAPE;
            ptr_reg     <= '0;
            xpos_reg    <= '0;
            ypos_reg    <= '0;
            active_reg  <= 1'b0;
            escaped_reg <= 1'b0;
            flip_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cause_reg   <= cause_next;
            ptr_reg     <= ptr_next;
            xpos_reg    <= xpos_next;
            ypos_reg    <= ypos_next;
            active_reg  <= active_next;
            escaped_reg <= escaped_next;
            flip_reg    <= flip_next;
        end
    end

endmodule

// File: tb/tb_enemy_path_reader.sv
// Self-checking bench for enemy_path_reader: directed paths plus random paths,
// checked against a waypoint-walking model over a behavioural ROM.
module tb_enemy_path_reader;

    localparam int AW = 10;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int ST = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          spawn;
    logic [AW-1:0] adr_start;
    logic          tick;
    logic          destroyed;
    logic [AW-1:0] rom_adr;
    logic [XW+YW:0] rom_data;
    logic [XW-1:0] xpos;
    logic [YW-1:0] ypos;
    logic          enemy_active;
    logic          escaped;
    logic          flip;

    logic [XW+YW:0] rom [0:DEPTH-1];

    int checks;
    int errors;
    int exp_flips;
    int flips_seen;
    logic [XW-1:0] last_x;
    logic [YW-1:0] last_y;

    enemy_path_reader #(
        .ADRESSWIDTH(AW),
        .XWIDTH     (XW),
        .YWIDTH     (YW),
        .STEP_TICKS (ST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spawn       (spawn),
        .adr_start   (adr_start),
        .tick        (tick),
        .destroyed   (destroyed),
        .rom_adr     (rom_adr),
        .rom_data    (rom_data),
        .xpos        (xpos),
        .ypos        (ypos),
        .enemy_active(enemy_active),
        .escaped     (escaped),
        .flip        (flip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_adr];

    always @(negedge clk) if (flip === 1'b1) flips_seen++;

    function automatic logic [XW+YW:0] mk(input logic e, input int x, input int y);
        logic [XW-1:0] xv;
        logic [YW-1:0] yv;
        xv = XW'(x);
        yv = YW'(y);
        return {e, xv, yv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // DONE cycle, then the single flip cycle, then back to quiet.
    task automatic finish_path(input logic exp_esc);
        check("flip_in_done", {31'd0, flip}, 32'd0);
        @(negedge clk);
        check("flip_pulse", {31'd0, flip}, 32'd1);
        check("escaped", {31'd0, escaped}, {31'd0, exp_esc});
        check("active_off", {31'd0, enemy_active}, 32'd0);
        check("xpos_hold", 32'(xpos), 32'(last_x));
        check("ypos_hold", 32'(ypos), 32'(last_y));
        exp_flips++;
        @(negedge clk);
        check("flip_single", {31'd0, flip}, 32'd0);
        check("escaped_single", {31'd0, escaped}, 32'd0);
    endtask

    task automatic do_spawn(input int start);
        adr_start = AW'(start);
        spawn = 1'b1;
        @(negedge clk);
        spawn = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Entered two edges after the spawn/last-tick edge; walks the model path.
    task automatic walk(input int start, input int kill_wp, input int kill_latch_wp);
        int idx;
        logic [XW+YW:0] w;
        idx = start;
        for (int wp = 0; wp < 64; wp++) begin
            w = rom[idx];
            if (w[XW+YW]) begin
                finish_path(1'b1);
                return;
            end
            check("xpos", 32'(xpos), 32'(w[XW+YW-1:YW]));
            check("ypos", 32'(ypos), 32'(w[YW-1:0]));
            check("active_on", {31'd0, enemy_active}, 32'd1);
            last_x = w[XW+YW-1:YW];
            last_y = w[YW-1:0];
            idx = (idx + 1) % DEPTH;
            if (wp == kill_wp) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                destroyed = 1'b1;
                @(negedge clk);
                destroyed = 1'b0;
                finish_path(1'b0);
                return;
            end
            for (int t = 0; t < ST; t++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                tick = 1'b1;
                @(negedge clk);
                tick = 1'b0;
                if (t < ST - 1) check("xpos_wait", 32'(xpos), 32'(last_x));
            end
            @(negedge clk);
            if (wp == kill_latch_wp) begin
                destroyed = 1'b1;
                @(negedge clk);
                destroyed = 1'b0;
                finish_path(1'b0);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $error("FAIL walk_bound: observed no end word expected end within 64 waypoints");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_flips = 0;
        flips_seen = 0;
        last_x = '0;
        last_y = '0;
        rst = 1'b1;
        spawn = 1'b0;
        adr_start = '0;
        tick = 1'b0;
        destroyed = 1'b0;

        for (int i = 0; i < DEPTH; i++) rom[i] = mk(1'b1, 0, 0);
        rom[5]    = mk(1'b0, 100, 200);
        rom[6]    = mk(1'b0, 110, 210);
        rom[7]    = mk(1'b1, 0, 0);
        rom[1023] = mk(1'b0, 1, 2);
        rom[0]    = mk(1'b1, 0, 0);
        rom[200]  = mk(1'b0, 7, 9);
        rom[201]  = mk(1'b1, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_xpos", 32'(xpos), 32'd0);
        check("rst_ypos", 32'(ypos), 32'd0);
        check("rst_rom_adr", 32'(rom_adr), 32'd0);
        check("rst_active", {31'd0, enemy_active}, 32'd0);
        check("rst_flip", {31'd0, flip}, 32'd0);
        check("rst_escaped", {31'd0, escaped}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic escape path.
        adr_start = AW'(5);
        spawn = 1'b1;
        @(negedge clk);
        spawn = 1'b0;
        check("rom_adr_start", 32'(rom_adr), 32'd5);
        @(negedge clk);
        @(negedge clk);
        walk(5, -1, -1);

        // Kill while waiting at 110/210.
        do_spawn(5);
        walk(5, 1, -1);

        // Kill coincides with the end word in LATCH.
        do_spawn(5);
        walk(5, -1, 1);

        // Pointer wraps from the top of the ROM.
        do_spawn(1023);
        walk(1023, -1, -1);

        // Spawn held high: no restart mid-path, next path starts from IDLE.
        adr_start = AW'(5);
        spawn = 1'b1;
        @(negedge clk);
        adr_start = AW'(200);
        @(negedge clk);
        @(negedge clk);
        walk(5, -1, -1);
        spawn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        walk(200, -1, -1);

        // Randomized paths, some empty, some killed.
        for (int p = 0; p < 6; p++) begin
            int base;
            int len;
            int kill;
            base = 300 + p * 80;
            len = $urandom_range(0, 4);
            for (int k = 0; k < len; k++)
                rom[base + k] = mk(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
            rom[base + len] = mk(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
            kill = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            do_spawn(base);
            walk(base, kill, -1);
        end

        // Reset while waiting: outputs clear, no flip.
        do_spawn(5);
        check("pre_rst_xpos", 32'(xpos), 32'd100);
        tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_xpos", 32'(xpos), 32'd0);
        check("midrst_ypos", 32'(ypos), 32'd0);
        check("midrst_rom_adr", 32'(rom_adr), 32'd0);
        check("midrst_active", {31'd0, enemy_active}, 32'd0);
        check("midrst_flip", {31'd0, flip}, 32'd0);
        @(negedge clk);
        check("midrst_flip2", {31'd0, flip}, 32'd0);
        rst = 1'b0;
        last_x = '0;
        last_y = '0;
        @(negedge clk);

        // Destroy in IDLE is ignored.
        destroyed = 1'b1;
        @(negedge clk);
        destroyed = 1'b0;
        @(negedge clk);
        check("idle_kill_flip", {31'd0, flip}, 32'd0);
        @(negedge clk);
        check("idle_kill_flip2", {31'd0, flip}, 32'd0);

        // Path still works after reset.
        do_spawn(5);
        walk(5, -1, -1);

        check("flip_count", 32'(flips_seen), 32'(exp_flips));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
